// File: rtl/serial_digit_pkg.sv
// ---------------------------------------------------------------------------
// serial_digit_pkg
// Shared types and constants for the digit-serial adder/subtractor.
//   state_t : packet framing state (expecting first digit / mid-packet)
//   OP_ADD  : packet computes a + b
//   OP_SUB  : packet computes a - b
// ---------------------------------------------------------------------------
package serial_digit_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_digit_pkg

// File: rtl/digit_add_cell.sv
// ---------------------------------------------------------------------------
// digit_add_cell
// Combinational one-digit adder with an optional inversion of b, used as
// the arithmetic core of the digit-serial adder/subtractor. Subtraction is
// a + ~b + 1, so the caller drives invert_b and seeds cin accordingly.
// Ports:
//   a, b      in  DIGIT_W  operand digits
//   invert_b  in  1        1 = use ~b (subtract)
//   cin       in  1        carry into bit 0
//   sum       out DIGIT_W  result digit
//   cout      out 1        carry out of bit DIGIT_W-1
//   c_msb     out 1        carry into bit DIGIT_W-1 (for signed overflow)
// ---------------------------------------------------------------------------
module digit_add_cell #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               invert_b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [DIGIT_W-1:0] b_x_s;
    logic [DIGIT_W:0]   full_s;

    assign b_x_s  = b ^ {DIGIT_W{invert_b}};
    assign full_s = {1'b0, a} + {1'b0, b_x_s} + {{DIGIT_W{1'b0}}, cin};

    assign sum  = full_s[DIGIT_W-1:0];
    assign cout = full_s[DIGIT_W];
    // The carry into the top bit is recovered from that bit's sum and its
    // two operands, which avoids slicing and keeps DIGIT_W=1 legal.
    assign c_msb = full_s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_x_s[DIGIT_W-1];

endmodule : digit_add_cell

// File: rtl/serial_digit_add_sub.sv
// ---------------------------------------------------------------------------
// serial_digit_add_sub
// Digit-serial adder/subtractor. Each valid cycle consumes one digit of a
// and b (least significant first) and the matching result digit appears on
// the registered outputs one cycle later. The operation is latched from
// sub on the first digit of each packet; a packet ends on last or when
// MAX_DIGITS digits have been accepted, whichever comes first.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   vld        input digit valid (a, b, last, sub qualified by it)
//   sub        0 = a+b, 1 = a-b; sampled on a packet's first digit only
//   a, b       operand digits
//   last       final (most significant) digit of the packet
//   out_vld    result digit valid
//   out_sum    result digit (held while out_vld is low)
//   out_last   result digit closes a packet
//   out_carry  final carry out (1 = no borrow for subtraction)
//   out_ovf    signed overflow of the whole packet
//   out_err    packet closed by the digit-count limit, not by last
// ---------------------------------------------------------------------------
import serial_digit_pkg::*;

module serial_digit_add_sub #(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    output logic               out_vld,
    output logic [DIGIT_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_ovf,
    output logic               out_err
);

    localparam int               CNT_W    = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               op_r;
    logic               op_nxt_s;
    logic               carry_r;
    logic               carry_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;

    logic               is_idle_s;
    logic               op_s;
    logic               cin_s;
    logic               end_s;
    logic [DIGIT_W-1:0] sum_s;
    logic               cout_s;
    logic               c_msb_s;

    // On the first digit the live sub input decides the operation, and it
    // also seeds the carry so that subtraction gets its +1.
    assign is_idle_s = (state_r == ST_IDLE);
    assign op_s      = is_idle_s ? sub : op_r;
    assign cin_s     = is_idle_s ? sub : carry_r;
    assign end_s     = last | (cnt_r == CNT_LAST);

    digit_add_cell #(
        .DIGIT_W (DIGIT_W)
    ) u_cell (
        .a        (a),
        .b        (b),
        .invert_b (op_s),
        .cin      (cin_s),
        .sum      (sum_s),
        .cout     (cout_s),
        .c_msb    (c_msb_s)
    );

    // Next-state logic for framing FSM, operation latch, carry and count.
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        carry_nxt_s = carry_r;
        cnt_nxt_s   = cnt_r;
        if (vld) begin
            if (end_s) begin
                // Closing digit: clear everything so the next packet is fresh.
                state_nxt_s = ST_IDLE;
                carry_nxt_s = 1'b0;
                cnt_nxt_s   = CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_nxt_s = ST_BUSY;
                        op_nxt_s    = sub;
                        carry_nxt_s = cout_s;
                        cnt_nxt_s   = CNT_ONE;
                    end
                    ST_BUSY: begin
                        state_nxt_s = ST_BUSY;
                        carry_nxt_s = cout_s;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        op_nxt_s    = OP_ADD;
                        carry_nxt_s = 1'b0;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
            op_nxt_s    = op_r;
            carry_nxt_s = carry_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // State registers with synchronous reset taking priority over vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= OP_ADD;
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            carry_r <= carry_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output registers: flags are pulses tied to the closing digit, the
    // result digit itself is held across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_sum   <= {DIGIT_W{1'b0}};
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_vld <= vld;
            if (vld) begin
                out_sum   <= sum_s;
                out_last  <= end_s;
                out_carry <= end_s & cout_s;
                out_ovf   <= end_s & (cout_s ^ c_msb_s);
                out_err   <= end_s & ~last;
            end else begin
                out_sum   <= out_sum;
                out_last  <= 1'b0;
                out_carry <= 1'b0;
                out_ovf   <= 1'b0;
                out_err   <= 1'b0;
            end
        end
    end

endmodule : serial_digit_add_sub

// File: tb/tb_serial_digit_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_digit_add_sub
// Directed bench for serial_digit_add_sub with DIGIT_W=4, MAX_DIGITS=4.
// Each record is one clock cycle of inputs together with the outputs
// expected right after that cycle's rising edge.
// ---------------------------------------------------------------------------
module tb_serial_digit_add_sub;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 4;

    logic               clk;
    logic               rst;
    logic               vld;
    logic               sub;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               last;
    logic               out_vld;
    logic [DIGIT_W-1:0] out_sum;
    logic               out_last;
    logic               out_carry;
    logic               out_ovf;
    logic               out_err;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       sub;
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
        logic       e_vld;
        logic [3:0] e_sum;
        logic       e_last;
        logic       e_carry;
        logic       e_ovf;
        logic       e_err;
    } vec_t;

    vec_t vecs [64];
    int   n_vecs;
    int   n_checks;
    int   n_errors;

    serial_digit_add_sub #(
        .DIGIT_W    (DIGIT_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .last      (last),
        .out_vld   (out_vld),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one cycle record: inputs then expected outputs.
    task automatic add_vec(input logic r, input logic v, input logic s,
                           input logic [3:0] ia, input logic [3:0] ib,
                           input logic l, input logic ev, input logic [3:0] es,
                           input logic el, input logic ec, input logic eo,
                           input logic ee);
        vec_t t;
        t.rst = r;  t.vld = v;  t.sub = s;  t.a = ia;  t.b = ib;  t.last = l;
        t.e_vld = ev; t.e_sum = es; t.e_last = el;
        t.e_carry = ec; t.e_ovf = eo; t.e_err = ee;
        vecs[n_vecs] = t;
        n_vecs++;
    endtask

    // Drive one cycle, then compare all outputs just after the rising edge.
    task automatic apply(input vec_t t, input string name);
        logic [8:0] act;
        logic [8:0] exp;
        @(negedge clk);
        rst  = t.rst;
        vld  = t.vld;
        sub  = t.sub;
        a    = t.a;
        b    = t.b;
        last = t.last;
        @(posedge clk);
        #1;
        act = {out_vld, out_sum, out_last, out_carry, out_ovf, out_err};
        exp = {t.e_vld, t.e_sum, t.e_last, t.e_carry, t.e_ovf, t.e_err};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got vld=%b sum=%h last=%b carry=%b ovf=%b err=%b, expected vld=%b sum=%h last=%b carry=%b ovf=%b err=%b",
                     name, act[8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; sub = 1'b0; a = 4'h0; b = 4'h0; last = 1'b0;
        n_vecs = 0; n_checks = 0; n_errors = 0;

        //       rst   vld   sub   a      b      last  e_vld e_sum  e_last e_c  e_o  e_e
        // Reset: everything zero.
        add_vec(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 0x1234 + 0x0FFF = 0x2233 (last and count limit coincide: no err).
        add_vec(1'b0, 1'b1, 1'b0, 4'h4, 4'hF, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h3, 4'hF, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h2, 4'hF, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        // 0x05 - 0x07 = 0xFE with borrow; sub=0 on 2nd digit is ignored.
        add_vec(1'b0, 1'b1, 1'b1, 4'h5, 4'h7, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        // 0x7F + 0x01 = 0x80: signed overflow.
        add_vec(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        // First scenario with 1, 2 and 3 idle gaps; idle last/sub are ignored.
        add_vec(1'b0, 1'b1, 1'b0, 4'h4, 4'hF, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h3, 4'hF, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h2, 4'hF, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        // Back-to-back single-digit packets: F+1, then 3-1.
        add_vec(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 4'h3, 4'h1, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < n_vecs; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Count limit: four add digits 0x8888+0x8888 without last close the
        // packet with err; sub=1 mid-packet is ignored. The 5th digit then
        // starts a new packet that re-samples sub (5-3 = 2, no borrow).
        apply({1'b0, 1'b1, 1'b0, 4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "limit_d0");
        apply({1'b0, 1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0}, "limit_d1");
        apply({1'b0, 1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0}, "limit_d2");
        apply({1'b0, 1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1}, "limit_d3_err");
        apply({1'b0, 1'b1, 1'b1, 4'h5, 4'h3, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0}, "limit_next_pkt");

        // Reset mid-packet with vld high: reset wins, outputs clear, and the
        // following packet sees no leftover carry (2+3 = 5, not 6).
        apply({1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "rst_d0");
        apply({1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0}, "rst_d1");
        apply({1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "rst_clear");
        apply({1'b0, 1'b1, 1'b0, 4'h2, 4'h3, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0}, "rst_fresh_pkt");
        apply({1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0}, "rst_idle_hold");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_digit_add_sub
